even_odd_stream_gen: RTL and testbench
======================================

# even_odd_stream_gen

Sequential source of 8-bit numbers with a selected parity, streamed over a valid/ready handshake. It produces operands for the even/odd classification path: a run is configured once, and the block emits `count` values starting from `seed`, filtered to the requested parity. Each emitted value carries its even/odd flags. Running even/odd totals allow a downstream checker to be cross-checked.

## Interface
Parameters:
- `WIDTH`, 8, data width of emitted values.
- `CNT_W`, 8, width of the run length and of the totals counters.

Ports:
- `clk`, input, 1, sole clock; all state changes on its rising edge.
- `rst_n`, input, 1, reset; asynchronous and active-low.
- `start`, input, 1, single-cycle run request; honoured only in IDLE.
- `mode`, input, 2, parity selection: 00 = all, 01 = even only, 10 = odd only, 11 = reserved (behaves as 00).
- `seed`, input, WIDTH, start value, sampled with `start`.
- `count`, input, CNT_W, number of values to emit, sampled with `start`.
- `busy`, output, 1, high whenever the FSM is not in IDLE.
- `out_valid`, output, 1, `out_data` is presented.
- `out_ready`, input, 1, consumer accepts.
- `out_data`, output, WIDTH, emitted value.
- `out_even`, output, 1, equals `~out_data[0]`.
- `out_odd`, output, 1, equals `out_data[0]`.
- `done`, output, 1, one-cycle pulse at run end.
- `even_total`, output, CNT_W, number of even values transferred in the current or last run.
- `odd_total`, output, CNT_W, number of odd values transferred in the current or last run.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN: `start` high with `count` != 0. On this transition:
  - latch `mode` and `count` into the remaining counter;
  - clear `even_total` and `odd_total`;
  - load `out_data` with the first value.
- IDLE → DONE: `start` high with `count` == 0. Nothing is emitted and the totals are cleared.
- First value:
  - `seed`, if the seed already has the requested parity or the mode is all/reserved;
  - otherwise `seed + 1`, mod 2^WIDTH (so 255 → 0).
- Step after each transfer: +1 in all mode, +2 in even/odd mode, mod 2^WIDTH. Wrap never changes parity because 2^WIDTH is even.
- Transfer: `out_valid && out_ready` in RUN. On each transfer:
  - decrement the remaining counter;
  - increment `even_total` or `odd_total` by the parity of `out_data`;
  - advance `out_data`.
- RUN → DONE: on the transfer that takes the remaining count to 0.
- DONE → IDLE: unconditional after one cycle. `done` is high only while in DONE.
- Handshake rules:
  - `out_valid` is high exactly while in RUN.
  - `out_data` stays stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a transfer.
- `start` is ignored while `busy`, with no effect on the latched configuration.
- Totals counters wrap mod 2^CNT_W. They cannot overflow within one run, since a run emits at most 2^CNT_W − 1 values.

## Timing
- Reset values:
  - state = IDLE;
  - `busy`, `out_valid`, `done` = 0;
  - `out_data` = 0, so `out_even` = 1 and `out_odd` = 0;
  - `even_total`, `odd_total` = 0.
- `start` sampled in cycle N → `busy` and `out_valid` high in cycle N+1, with the first value on `out_data`.
- With `out_ready` held high: one transfer per cycle. A run of `count` values occupies cycles N+1 … N+count.
- Last transfer in cycle M → cycle M+1: `out_valid` = 0, `done` = 1, totals final. Cycle M+2: `busy` = 0, and a new `start` is accepted.
- `count` = 0: `start` in cycle N → `done` = 1 and `busy` = 1 in N+1, IDLE in N+2.
- Reset asserted mid-run: all outputs return to reset values immediately, independent of `clk`. The run is abandoned, with no `done` pulse.

## Structure
- Package `even_odd_pkg`:
  - `mode_t` enum (MODE_ALL, MODE_EVEN, MODE_ODD, MODE_RSVD);
  - `state_t` enum (S_IDLE, S_RUN, S_DONE);
  - localparam defaults for WIDTH and CNT_W.
- Sub-module `even_odd_step` (combinational): given the current value, the mode, and a first-value flag, returns the next value (parity fix-up or +1/+2 with wrap). It is instantiated once.
- Everything else (FSM, counters, output register) is in the top module.

## Test plan
- Even run: `seed`=2, `mode`=01, `count`=4, `out_ready`=1 → `out_data` 2, 4, 6, 8 on consecutive cycles, `out_even`=1 each; `done` 1 cycle after the value 8; `even_total`=4, `odd_total`=0.
- Odd fix-up with wrap: `seed`=254, `mode`=10, `count`=3 → 255, 1, 3; all have `out_odd`=1; `odd_total`=3.
- All mode with backpressure: `seed`=14, `mode`=00, `count`=3, `out_ready` low for 2 cycles on the second value → 14, 15, 16. The value 15 is held stable with `out_valid` high through the stall. Final totals: `even_total`=2, `odd_total`=1.
- Zero count and ignored start: `count`=0 → no `out_valid`, `done` pulse in N+1. A `start` with `seed`=8 asserted mid-run does not change the sequence.
- Reset mid-run: after 2 of 5 values, pulse `rst_n` low → outputs go to reset values immediately. A subsequent `start` (`seed`=3, `mode`=00, `count`=1) emits 3, then `done`.

Source files
------------

// File: rtl/even_odd_pkg.sv
// Shared types and default widths for the even/odd operand stream generator.
package even_odd_pkg;

   typedef enum logic [1:0] {
      MODE_ALL  = 2'b00,
      MODE_EVEN = 2'b01,
      MODE_ODD  = 2'b10,
      MODE_RSVD = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/even_odd_step.sv
// Next-value generator: parity fix-up of the seed on the first value, else +1 (all) or +2 (even/odd).
// Purely combinational; wraps mod 2^WIDTH, which never changes parity.
module even_odd_step
   import even_odd_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] cur,
   input  logic [1:0]       mode,
   input  logic             first,
   output logic [WIDTH-1:0] nxt
);

   mode_t mode_e;
   logic  filtered;
   logic  wrong_parity;

   always_comb begin
      mode_e       = mode_t'(mode);
      filtered     = (mode_e == MODE_EVEN) || (mode_e == MODE_ODD);
      wrong_parity = ((mode_e == MODE_EVEN) &&  cur[0]) ||
                     ((mode_e == MODE_ODD)  && !cur[0]);
      nxt          = cur;
      if (first) begin
         if (wrong_parity) nxt = cur + WIDTH'(1);
      end else if (filtered) begin
         nxt = cur + WIDTH'(2);
      end else begin
         nxt = cur + WIDTH'(1);
      end
   end

endmodule

// File: rtl/even_odd_stream_gen.sv
// Streams count values from seed filtered by parity over valid/ready; first value one cycle after start.
// out_data is held while out_valid && !out_ready; done pulses one cycle after the last transfer.
module even_odd_stream_gen
   import even_odd_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] seed,
   input  logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_even,
   output logic             out_odd,
   output logic             done,
   output logic [CNT_W-1:0] even_total,
   output logic [CNT_W-1:0] odd_total
);

   state_t           state_q, state_d;
   mode_t            mode_q, mode_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] even_total_q, even_total_d;
   logic [CNT_W-1:0] odd_total_q, odd_total_d;

   logic [WIDTH-1:0] step_cur;
   logic [1:0]       step_mode;
   logic             step_first;
   logic [WIDTH-1:0] step_nxt;

   // One step unit serves both the seed fix-up (in IDLE) and the per-transfer advance.
   assign step_first = (state_q == S_IDLE);
   assign step_cur   = step_first ? seed : data_q;
   assign step_mode  = step_first ? mode : mode_q;

   even_odd_step #(.WIDTH(WIDTH)) u_step (
      .cur   (step_cur),
      .mode  (step_mode),
      .first (step_first),
      .nxt   (step_nxt)
   );

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      rem_d        = rem_q;
      data_d       = data_q;
      even_total_d = even_total_q;
      odd_total_d  = odd_total_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               even_total_d = '0;
               odd_total_d  = '0;
               if (count == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
                  mode_d  = mode_t'(mode);
                  rem_d   = count;
                  data_d  = step_nxt;
               end
            end
         end
         S_RUN: begin
            if (out_ready) begin
               rem_d  = rem_q - CNT_W'(1);
               data_d = step_nxt;
               if (data_q[0]) odd_total_d  = odd_total_q + CNT_W'(1);
               else           even_total_d = even_total_q + CNT_W'(1);
               if (rem_q == CNT_W'(1)) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         mode_q       <= MODE_ALL;
         rem_q        <= '0;
         data_q       <= '0;
         even_total_q <= '0;
         odd_total_q  <= '0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         rem_q        <= rem_d;
         data_q       <= data_d;
         even_total_q <= even_total_d;
         odd_total_q  <= odd_total_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign out_valid  = (state_q == S_RUN);
   assign done       = (state_q == S_DONE);
   assign out_data   = data_q;
   assign out_even   = ~data_q[0];
   assign out_odd    = data_q[0];
   assign even_total = even_total_q;
   assign odd_total  = odd_total_q;

endmodule

// File: tb/tb_even_odd_stream_gen.sv
// Bench for even_odd_stream_gen: directed table, hand-written corner sequences, and random runs
// checked against an arithmetic model of the emitted sequence.
module tb_even_odd_stream_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [1:0] mode;
   logic [7:0] seed;
   logic [7:0] count;
   logic       busy;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_even;
   logic       out_odd;
   logic       done;
   logic [7:0] even_total;
   logic [7:0] odd_total;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   even_odd_stream_gen #(.WIDTH(8), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .mode       (mode),
      .seed       (seed),
      .count      (count),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_even   (out_even),
      .out_odd    (out_odd),
      .done       (done),
      .even_total (even_total),
      .odd_total  (odd_total)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Model: value k of a run is first + k*step mod 256, first being the seed nudged to the right parity.
   task automatic do_run(input logic [7:0] s, input logic [1:0] m, input logic [7:0] c,
                         input int pct, output int first_o, output int last_o,
                         output int ev_o, output int od_o);
      int q[$];
      int first_v, stepv, v, exp_ev, exp_od, cyc;
      exp_ev  = 0;
      exp_od  = 0;
      cyc     = 0;
      first_v = s;
      if ((m == 2'b01 && s[0]) || (m == 2'b10 && !s[0])) first_v = (s + 1) % 256;
      stepv = (m == 2'b01 || m == 2'b10) ? 2 : 1;
      for (int k = 0; k < c; k++) begin
         v = (first_v + k * stepv) % 256;
         q.push_back(v);
         if (v % 2 == 1) exp_od++;
         else            exp_ev++;
      end
      first_o = -1;
      last_o  = -1;
      start = 1'b1; seed = s; mode = m; count = c;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      if (c == 0) begin
         chk("zero_no_valid", out_valid, 0);
         chk("zero_done", done, 1);
      end else begin
         while (q.size() > 0 && cyc < 4 * c + 20) begin
            chk("valid_in_run", out_valid, 1);
            chk("data", out_data, q[0]);
            chk("parity_flags", {out_even, out_odd}, (q[0] % 2 == 1) ? 1 : 2);
            out_ready = ($urandom_range(1, 100) <= pct);
            if (out_ready) begin
               if (first_o < 0) first_o = out_data;
               last_o = out_data;
               q.delete(0);
            end
            cyc++;
            @(negedge clk);
         end
         chk("run_timeout_left", q.size(), 0);
         chk("done_after_last", done, 1);
         chk("valid_low_at_done", out_valid, 0);
      end
      chk("even_total_model", even_total, exp_ev);
      chk("odd_total_model", odd_total, exp_od);
      ev_o = even_total;
      od_o = odd_total;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
   endtask

   typedef struct {
      logic [7:0] s;
      logic [1:0] m;
      logic [7:0] c;
      int first_v;
      int last_v;
      int ev;
      int od;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int f, l, e, o;

      vecs[0] = '{8'd2,   2'b01, 8'd4,   2,   8,   4,   0};
      vecs[1] = '{8'd254, 2'b10, 8'd3,   255, 3,   0,   3};
      vecs[2] = '{8'd255, 2'b01, 8'd2,   0,   2,   2,   0};
      vecs[3] = '{8'd7,   2'b11, 8'd3,   7,   9,   1,   2};
      vecs[4] = '{8'd5,   2'b00, 8'd0,   -1,  -1,  0,   0};
      vecs[5] = '{8'd0,   2'b00, 8'd255, 0,   254, 128, 127};

      rst_n = 1'b0; start = 1'b0; mode = 2'b00; seed = 8'd0; count = 8'd0; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_data", out_data, 0);
      chk("rst_even", out_even, 1);
      chk("rst_odd", out_odd, 0);
      chk("rst_even_total", even_total, 0);
      chk("rst_odd_total", odd_total, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         do_run(vecs[i].s, vecs[i].m, vecs[i].c, 100, f, l, e, o);
         chk("tbl_first", f, vecs[i].first_v);
         chk("tbl_last", l, vecs[i].last_v);
         chk("tbl_even_total", e, vecs[i].ev);
         chk("tbl_odd_total", o, vecs[i].od);
      end

      // Backpressure: 15 held for two stalled cycles.
      start = 1'b1; seed = 8'd14; mode = 2'b00; count = 8'd3; out_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("bp_v0", out_data, 14);
      @(negedge clk);
      chk("bp_v1", out_data, 15);
      out_ready = 1'b0;
      @(negedge clk);
      chk("bp_stall1_valid", out_valid, 1);
      chk("bp_stall1_data", out_data, 15);
      @(negedge clk);
      chk("bp_stall2_valid", out_valid, 1);
      chk("bp_stall2_data", out_data, 15);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_v2", out_data, 16);
      @(negedge clk);
      chk("bp_done", done, 1);
      chk("bp_even_total", even_total, 2);
      chk("bp_odd_total", odd_total, 1);
      @(negedge clk);
      chk("bp_idle", busy, 0);

      // A start asserted mid-run must not disturb the sequence.
      start = 1'b1; seed = 8'd2; mode = 2'b01; count = 8'd4; out_ready = 1'b1;
      @(negedge clk);
      chk("ign_v0", out_data, 2);
      start = 1'b1; seed = 8'd8; mode = 2'b00; count = 8'd0;
      @(negedge clk); start = 1'b0;
      chk("ign_v1", out_data, 4);
      @(negedge clk);
      chk("ign_v2", out_data, 6);
      @(negedge clk);
      chk("ign_v3", out_data, 8);
      chk("ign_v3_valid", out_valid, 1);
      @(negedge clk);
      chk("ign_done", done, 1);
      chk("ign_even_total", even_total, 4);
      @(negedge clk);
      chk("ign_idle", busy, 0);

      // Asynchronous reset mid-run, between clock edges.
      start = 1'b1; seed = 8'd10; mode = 2'b00; count = 8'd5; out_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rr_pre_data", out_data, 12);
      #2 rst_n = 1'b0;
      #1;
      chk("rr_busy", busy, 0);
      chk("rr_valid", out_valid, 0);
      chk("rr_done", done, 0);
      chk("rr_data", out_data, 0);
      chk("rr_even", out_even, 1);
      chk("rr_odd", out_odd, 0);
      chk("rr_even_total", even_total, 0);
      chk("rr_odd_total", odd_total, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rr_no_done", done, 0);
      do_run(8'd3, 2'b00, 8'd1, 100, f, l, e, o);
      chk("rr_next_first", f, 3);
      chk("rr_next_odd_total", o, 1);

      for (int r = 0; r < 25; r++) begin
         do_run(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                8'($urandom_range(0, 12)), $urandom_range(40, 100), f, l, e, o);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
